// File: rtl/bp_pkg.sv
// Shared types and helpers for the BHT branch predictor.
// Counter helpers take the width as an argument so one copy serves every table.
package bp_pkg;

    localparam int BP_IDX_W = 6;

    typedef struct packed {
        logic                valid;
        logic                pred_taken;
        logic [BP_IDX_W-1:0] idx;
    } fd_t;

    // Weakly-not-taken: MSB clear, all lower bits set.
    function automatic logic [31:0] ctr_reset_val(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v, input int w);
        logic [31:0] unused_w;
        unused_w = 32'(w);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

endpackage

// File: rtl/bht_table.sv
// Saturating-counter branch history table.
// One combinational read port for fetch, one training port for decode.
module bht_table
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_taken,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic                  wr_taken
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT =
        CTR_BITS'(ctr_reset_val(CTR_BITS));

    logic [CTR_BITS-1:0] mem [ENTRIES];
    logic [CTR_BITS-1:0] upd;

    always_comb begin
        upd = mem[wr_idx];
        if (wr_taken)
            upd = CTR_BITS'(sat_inc(32'(mem[wr_idx]), CTR_BITS));
        else
            upd = CTR_BITS'(sat_dec(32'(mem[wr_idx]), CTR_BITS));
    end

    // Read sees the pre-edge value; a same-index write lands at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                mem[i] <= CTR_INIT;
        end else if (wr_en) begin
            mem[wr_idx] <= upd;
        end
    end

    assign rd_taken = mem[rd_idx][CTR_BITS-1];

endmodule

// File: rtl/branch_predictor_bht.sv
// Dynamic branch predictor: BHT lookup in F, resolve/train in D,
// plus saturating branch and mispredict statistics.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = BP_IDX_W,
    parameter int CTR_BITS   = 2,
    parameter int STAT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          pc_f,
    input  logic                 stall_d,
    input  logic                 flush_d,
    input  logic                 branch_d,
    input  logic                 taken_d,
    output logic                 predict_taken_f,
    output logic                 pred_taken_d,
    output logic                 mispredict_d,
    output logic [STAT_BITS-1:0] branch_count,
    output logic [STAT_BITS-1:0] mispredict_count
);

    logic [INDEX_BITS-1:0] idx_f;
    logic [INDEX_BITS-1:0] idx_d;
    logic                  resolve;
    logic                  unused_pc;
    fd_t                   fd_q;

    assign idx_f     = pc_f[INDEX_BITS+1:2];
    assign unused_pc = ^{pc_f[31:INDEX_BITS+2], pc_f[1:0]};

    bht_table #(
        .INDEX_BITS (INDEX_BITS),
        .CTR_BITS   (CTR_BITS)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (idx_f),
        .rd_taken (predict_taken_f),
        .wr_en    (resolve),
        .wr_idx   (idx_d),
        .wr_taken (taken_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fd_q <= '0;
        end else if (flush_d) begin
            fd_q.valid      <= 1'b0;
            fd_q.pred_taken <= 1'b0;
        end else if (!stall_d) begin
            fd_q.valid      <= 1'b1;
            fd_q.pred_taken <= predict_taken_f;
            fd_q.idx        <= BP_IDX_W'(idx_f);
        end
    end

    assign idx_d        = INDEX_BITS'(fd_q.idx);
    assign pred_taken_d = fd_q.pred_taken;

    // eq_d is not final while stalled, so nothing resolves then.
    assign resolve      = fd_q.valid & branch_d & ~stall_d;
    assign mispredict_d = resolve & (fd_q.pred_taken != taken_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (resolve)
                branch_count <= STAT_BITS'(
                    sat_inc(32'(branch_count), STAT_BITS));
            if (mispredict_d)
                mispredict_count <= STAT_BITS'(
                    sat_inc(32'(mispredict_count), STAT_BITS));
        end
    end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
Parametrised dynamic branch predictor for the 5-stage MIPS core. It sits beside the core controller.
- Fetch: indexes a branch history table (BHT) of saturating counters by PC and supplies a taken/not-taken prediction.
- Decode: carries the prediction down one stage, compares it with the resolved branch outcome, flags mispredicts and trains the table.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
INDEX_BITS, 6, log2 of BHT entries (64 entries); index = pc_f[INDEX_BITS+1:2]
CTR_BITS, 2, width of each saturating counter; prediction = counter MSB
STAT_BITS, 16, width of branch/mispredict statistics counters

Ports:
clk  input  1  core clock, rising edge
reset  input  1  synchronous, active-high
pc_f  input  32  fetch-stage PC
stall_d  input  1  hazard unit holds F/D register
flush_d  input  1  clears F/D register (taken branch / jump / restart)
branch_d  input  1  decode instruction is a conditional branch
taken_d  input  1  resolved outcome in D (branch_d & eq_d)
predict_taken_f  output  1  prediction for the instruction at pc_f
pred_taken_d  output  1  prediction carried into D
mispredict_d  output  1  resolved outcome differs from prediction, D stage
branch_count  output  STAT_BITS  resolved branches seen
mispredict_count  output  STAT_BITS  mispredicts seen

Behaviour:
- Clock is clk; reset is synchronous and active-high; everything updates on the rising edge of clk.
- Reset (including mid-operation):
  - all BHT counters go to weakly-not-taken: MSB 0, remaining bits all 1 (2'b01 for CTR_BITS=2);
  - F/D register cleared: valid_d=0, pred_taken_d=0, idx_d=0;
  - branch_count=0, mispredict_count=0;
  - hence predict_taken_f=0 and mispredict_d=0 in the first cycle after reset.
- F stage (combinational): idx_f = pc_f[INDEX_BITS+1:2]; predict_taken_f = bht[idx_f][CTR_BITS-1].
- F/D register, priority reset > flush_d > stall_d > load:
  - flush_d: valid_d=0, pred_taken_d=0.
  - stall_d (no flush): hold all.
  - otherwise: valid_d=1, pred_taken_d=predict_taken_f, idx_d=idx_f.
- Resolve (D) = valid_d & branch_d & !stall_d. No resolve while stalled, because eq_d is not yet final.
- mispredict_d = resolve & (pred_taken_d != taken_d). It is combinational, so the core uses it in the same cycle to redirect and flush.
- Training on resolve, at the next edge:
  - bht[idx_d] increments if taken_d, saturating at all-ones;
  - otherwise it decrements, saturating at 0;
  - with no resolve the table is unchanged.
- Simultaneous F read and D write to the same index: F sees the old value (no bypass); the write lands at the edge.
- Statistics:
  - on resolve, branch_count += 1;
  - on mispredict_d, mispredict_count += 1;
  - both saturate at all-ones and never wrap.
- flush_d and resolve in the same cycle: training and stats still happen for the instruction in D; the flush only affects the incoming F/D load.
- Latency: prediction is 0 cycles (combinational from pc_f); training is visible to F reads one cycle after resolve.
- Aliasing: distinct PCs sharing index bits share a counter; this is intended, and no tag is kept.

Decomposition:
- Package bp_pkg holds:
  - a localparam function for the counter reset value (weakly-not-taken for any CTR_BITS);
  - sat_inc/sat_dec functions parametrised by width;
  - the F/D register struct {valid, pred_taken, idx}.
- One sub-module, bht_table: 2^INDEX_BITS x CTR_BITS storage with synchronous reset, one async read port and one saturating update port (en, idx, taken).
- The top level holds the F/D register, resolve/mispredict logic and stats counters.

Test Plan:
1. Reset, then pc_f=0x00400010 → predict_taken_f=0; both counts 0; every entry reads 2'b01.
2. Branch at idx 4 (pc 0x10): resolve taken 3 times → counter 01→10→11→11 (saturates); predict_taken_f=1 from the cycle after the first resolve; mispredict_d=1 only on the first resolve; mispredict_count=1, branch_count=3.
3. Same entry, then 4 not-taken resolves → 11→10→01→00→00; mispredict_d=1 on the first two only; prediction flips to 0 after the second.
4. branch_d=1 with stall_d=1 for 2 cycles, then stall_d=0 with taken_d=1 → exactly one update and branch_count +1; no mispredict_d while stalled.
5. flush_d=1 with a predicted-taken pc_f → next cycle valid_d=0, and branch_d=1 produces no update and no count change; then reset asserted mid-training → all counters back to 01 and stats back to 0.
6. With STAT_BITS=4, 20 mispredicting branches → mispredict_count holds at 4'hF and does not wrap; read/write collision at the same index → F sees the old counter for one cycle.
